// File: rtl/dsp_pipe_line.sv
// dsp_pipe_line: DEPTH-stage pipeline register with a per-stage valid flag,
// synchronous clear and a registered occupancy counter. Sits between the port
// muxes and the arithmetic units so operand/multiplier/post-adder paths can be
// retimed and drained.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   ce        clock enable: 1 = advance all stages, 0 = hold
//   sclr      synchronous clear, overrides ce
//   in_data   sample entering stage 0
//   in_valid  in_data carries a real sample
//   out_data  sample leaving the last stage (registered)
//   out_valid out_data carries a real sample (registered)
//   fill_cnt  number of valid samples currently in the pipe (registered)
//   busy      fill_cnt != 0 (combinational from fill_cnt)
//
// DEPTH = 0 is a pure combinational pass-through; fill_cnt and busy are then 0.
module dsp_pipe_line #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    fill_cnt,
  output logic             busy
);

  // Reject unsupported geometries at elaboration.
  if (WIDTH < 1 || WIDTH > 64 || DEPTH > 8) begin : g_bad_param
    $error("dsp_pipe_line: WIDTH must be 1..64 and DEPTH 0..8");
  end

  if (DEPTH == 0) begin : g_pass
    // Wire-through; clock and control inputs have no effect.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst, ce, sclr};

    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign fill_cnt  = '0;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [CW-1:0]    cnt_q;

    // Stage shift and occupancy tracking; priority rst > sclr > ce.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= '0;
        vld_q <= '0;
        cnt_q <= '0;
      end else if (sclr) begin
        for (int k = 0; k < int'(DEPTH); k++) data_q[k] <= '0;
        vld_q <= '0;
        cnt_q <= '0;
      end else if (ce) begin
        data_q[0] <= in_data;
        vld_q[0]  <= in_valid;
        for (int k = 1; k < int'(DEPTH); k++) begin
          data_q[k] <= data_q[k-1];
          vld_q[k]  <= vld_q[k-1];
        end
        // Valid in with valid out on the same edge leaves the count alone.
        if (in_valid && !vld_q[DEPTH-1]) begin
          cnt_q <= cnt_q + CW'(1);
        end else if (!in_valid && vld_q[DEPTH-1]) begin
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];
    assign fill_cnt  = cnt_q;
  end

  assign busy = (fill_cnt != '0);

endmodule
